// File: rtl/ame_equation_builder.sv
// Producer side of the affine ME solver: folds a per-pixel gradient stream into
// the symmetric 6x7 normal-equation system A|B and hands it to the solver.

// One matrix element: registered product (stage 2) feeding a wrapping accumulator (stage 3).
module ame_eq_mac #(
   parameter int AW = 25,
   parameter int DW = 64
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          clr_i,
   input  logic          prod_en_i,
   input  logic          acc_en_i,
   input  logic [AW-1:0] a_i,
   input  logic [AW-1:0] b_i,
   output logic [DW-1:0] acc_o
);
   localparam int PW = 2*AW;

   logic [PW-1:0] a_x, b_x, prod_d, prod_q;

   assign a_x = {{AW{a_i[AW-1]}}, a_i};
   assign b_x = {{AW{b_i[AW-1]}}, b_i};
   // Low PW bits of an unsigned multiply of sign-extended operands are the signed product.
   assign prod_d = a_x * b_x;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i)       prod_q <= '0;
      else if (prod_en_i) prod_q <= prod_d;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i)      acc_o <= '0;
      else if (clr_i)    acc_o <= '0;
      else if (acc_en_i) acc_o <= acc_o + {{(DW-PW){prod_q[PW-1]}}, prod_q};
endmodule

module ame_equation_builder #(
   parameter int COMP_DATA_BITS = 64,
   parameter int GRAD_BITS      = 16,
   parameter int POS_BITS       = 7
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   input  logic                                start_i,
   input  logic                                affine_param6_i,
   input  logic                                s_valid_i,
   output logic                                s_ready_o,
   input  logic                                s_last_i,
   input  logic [GRAD_BITS-1:0]                gx_i,
   input  logic [GRAD_BITS-1:0]                gy_i,
   input  logic [POS_BITS-1:0]                 pos_x_i,
   input  logic [POS_BITS-1:0]                 pos_y_i,
   input  logic [GRAD_BITS-1:0]                err_i,
   output logic                                solver_init_o,
   output logic                                solver_param6_o,
   output logic [5:0][6:0][COMP_DATA_BITS-1:0] solver_data_o,
   input  logic                                solver_done_i,
   output logic                                done_o
);
   localparam int CW = GRAD_BITS + POS_BITS + 2;
   localparam int NA = 21;

   typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, ISSUE, WAIT} state_t;

   state_t                          state_q, state_d;
   logic [1:0]                      flush_cnt_q, flush_cnt_d;
   logic                            done_d, clr, hs;
   logic [1:0]                      vld_pipe;
   logic signed [CW-1:0]            gx, gy, px, py;
   logic [5:0][CW-1:0]              c_d, c_q;
   logic [CW-1:0]                   e_q;
   logic [NA-1:0][COMP_DATA_BITS-1:0] acc_a;
   logic [5:0][COMP_DATA_BITS-1:0]  acc_b;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state_q         <= IDLE;
         flush_cnt_q     <= '0;
         done_o          <= 1'b0;
         solver_param6_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         done_o      <= done_d;
         if (clr) solver_param6_o <= affine_param6_i;
      end

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      s_ready_o     = 1'b0;
      solver_init_o = 1'b0;
      clr           = 1'b0;
      done_d        = 1'b0;
      case (state_q)
         IDLE:  if (start_i) begin
                   clr     = 1'b1;
                   state_d = ACCUM;
                end
         ACCUM: begin
                   s_ready_o = 1'b1;
                   if (s_valid_i && s_last_i) begin
                      state_d     = FLUSH;
                      flush_cnt_d = '0;
                   end
                end
         // Last sample reaches the accumulator after the third flush cycle.
         FLUSH: if (flush_cnt_q == 2'd2) state_d = ISSUE;
                else flush_cnt_d = flush_cnt_q + 2'd1;
         ISSUE: begin
                   solver_init_o = 1'b1;
                   state_d       = WAIT;
                end
         WAIT:  if (solver_done_i) begin
                   done_d  = 1'b1;
                   state_d = IDLE;
                end
         default: state_d = IDLE;
      endcase
   end

   assign hs = s_valid_i & s_ready_o;

   assign gx = {{(CW-GRAD_BITS){gx_i[GRAD_BITS-1]}}, gx_i};
   assign gy = {{(CW-GRAD_BITS){gy_i[GRAD_BITS-1]}}, gy_i};
   assign px = {{(CW-POS_BITS){1'b0}}, pos_x_i};
   assign py = {{(CW-POS_BITS){1'b0}}, pos_y_i};

   always_comb begin
      c_d = '0;
      if (solver_param6_o) begin
         c_d[0] = gx;
         c_d[1] = px * gx;
         c_d[2] = gy;
         c_d[3] = px * gy;
         c_d[4] = py * gx;
         c_d[5] = py * gy;
      end else begin
         c_d[2] = gx;
         c_d[3] = px * gx + py * gy;
         c_d[4] = gy;
         c_d[5] = py * gx - px * gy;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         vld_pipe <= '0;
         c_q      <= '0;
         e_q      <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], hs};
         if (hs) begin
            c_q <= c_d;
            e_q <= {{(CW-GRAD_BITS){err_i[GRAD_BITS-1]}}, err_i};
         end
      end

   // Upper triangle stored row-major; row i starts at 6i - i(i-1)/2.
   for (genvar i = 0; i < 6; i++) begin : g_row
      for (genvar j = i; j < 6; j++) begin : g_a
         localparam int K = 6*i - (i*(i-1))/2 + j - i;
         ame_eq_mac #(.AW(CW), .DW(COMP_DATA_BITS)) u_mac (
            .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr),
            .prod_en_i(vld_pipe[0]), .acc_en_i(vld_pipe[1]),
            .a_i(c_q[i]), .b_i(c_q[j]), .acc_o(acc_a[K]));
      end
      ame_eq_mac #(.AW(CW), .DW(COMP_DATA_BITS)) u_mac_b (
         .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr),
         .prod_en_i(vld_pipe[0]), .acc_en_i(vld_pipe[1]),
         .a_i(c_q[i]), .b_i(e_q), .acc_o(acc_b[i]));
      for (genvar j = 0; j < 6; j++) begin : g_out
         localparam int LO = (i < j) ? i : j;
         localparam int HI = (i < j) ? j : i;
         assign solver_data_o[i][j] = acc_a[6*LO - (LO*(LO-1))/2 + HI - LO];
      end
      assign solver_data_o[i][6] = acc_b[i];
   end
endmodule

// File: doc/ame_equation_builder.md
Name: ame_equation_builder

Overview:
- Producer side of the affine motion-estimation equation solver.
- Consumes a per-pixel stream of gradients, positions and prediction error for one CU.
- Accumulates the symmetric normal-equation system A|B (6x7, 64-bit signed integers) and hands it to the solver with a one-cycle init pulse.
- Holds the matrix stable until the solver reports done, then signals completion upstream.

Parameters:
COMP_DATA_BITS, 64, accumulator / matrix element width (signed two's complement)
GRAD_BITS, 16, signed width of gx_i, gy_i, err_i
POS_BITS, 7, unsigned width of pixel position within CU (0..127)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  begin new CU; sampled in IDLE only
affine_param6_i  in  1  1 = 6-parameter model, 0 = 4-parameter; latched on start_i
s_valid_i  in  1  sample valid
s_ready_o  out  1  sample accepted when s_valid_i & s_ready_o
s_last_i  in  1  marks final sample of CU
gx_i, gy_i  in  GRAD_BITS each  signed horizontal / vertical gradient
pos_x_i, pos_y_i  in  POS_BITS each  unsigned sample position
err_i  in  GRAD_BITS  signed (original - prediction)
solver_init_o  out  1  one-cycle pulse to solver comp_init
solver_param6_o  out  1  latched model flag to solver affine_param6
solver_data_o  out  6x7xCOMP_DATA_BITS  packed [5:0][6:0] matrix, [i][6] = B_i
solver_done_i  in  1  solver comp_done
done_o  out  1  one-cycle pulse, CU finished

Behaviour:
- Reset: state IDLE; all accumulators, solver_data_o, s_ready_o, solver_init_o, solver_param6_o, done_o = 0.
- Clock: clk_i. Reset: rst_n_i, asynchronous, active-low. Reset mid-operation aborts the CU and clears everything; no done_o is issued.
- States:
  - IDLE: on start_i, clear accumulators, latch affine_param6_i, go to ACCUM.
  - ACCUM: s_ready_o = 1. A handshake carrying s_last_i goes to FLUSH.
  - FLUSH: 3 cycles to drain the pipeline, then ISSUE.
  - ISSUE: solver_init_o = 1 for exactly one cycle, then WAIT.
  - WAIT: on solver_done_i, done_o = 1 for one cycle, go to IDLE.
- start_i outside IDLE is ignored. s_ready_o = 0 in every state except ACCUM.
- solver_done_i outside WAIT is ignored. If solver_done_i arrives in the same cycle as ISSUE, it is ignored.
- Coefficient vector c[0..5], each signed GRAD_BITS+POS_BITS+2 bits:
  - 6-param: c0=gx, c1=x*gx, c2=gy, c3=x*gy, c4=y*gx, c5=y*gy.
  - 4-param: c0=c1=0, c2=gx, c3=x*gx+y*gy, c4=gy, c5=y*gx-x*gy. Rows/cols 0,1 remain 0.
- Pipeline:
  - Stage 1 registers c.
  - Stage 2 registers the 21 upper-triangle products c_i*c_j (i<=j) and the 6 products c_i*err.
  - Stage 3 sign-extends each product to COMP_DATA_BITS and adds it into the accumulator.
  - A sample accepted at cycle t is visible in the accumulator at t+3.
- solver_data_o[i][j] = A[min(i,j)][max(i,j)] (symmetric mirror); solver_data_o[i][6] = B_i.
  - Driven directly from the accumulator registers.
  - Stable from ISSUE through WAIT; not cleared until the next start_i.
- Overflow: no overflow for CUs up to 128x128 with full-range inputs. Otherwise arithmetic wraps modulo 2^COMP_DATA_BITS, with no saturation.
- A singular system (solver done early on zero pivot) is treated identically; done_o still pulses once.

Test Plan:
- 6-param, single sample gx=1, gy=0, x=2, y=3, err=5, last=1 -> solver_data_o[0][0]=1, [0][1]=[1][0]=2, [0][4]=3, [1][1]=4, [1][4]=6, [4][4]=9, [0][6]=5, [1][6]=10, [4][6]=15, all else 0. solver_init_o pulses exactly 4 cycles after the last handshake.
- 4-param, single sample gx=1, gy=2, x=3, y=4, err=1 -> c=[0,0,1,11,2,-2]. [2][3]=11, [3][3]=121, [2][5]=-2 (0xFFFF_FFFF_FFFF_FFFE), [5][5]=4, [3][6]=11, [5][6]=-2. Rows 0,1 all 0. solver_param6_o=0.
- Stream of 16 identical 6-param samples with random s_valid_i gaps -> every element equals 16x the single-sample value. Samples presented while s_ready_o=0 (FLUSH/ISSUE/WAIT) are not accumulated.
- Hold solver_done_i low for 50 cycles in WAIT -> solver_data_o unchanged, no done_o, start_i ignored. Assert solver_done_i -> done_o pulses the next cycle, state returns to IDLE.
- Two back-to-back CUs with different data -> the second matrix has no residue from the first.
- Deassert rst_n_i during ACCUM after 5 samples -> all outputs immediately 0. A new start_i produces a matrix built from new samples only.
